// File: rtl/edge_detector_multi.sv
// rtl/edge_detector_multi.sv - multi-channel synchronised, debounced edge detector with qualified events and sticky flags
//
// Purpose:
//    Each of CH independent channels takes a raw asynchronous input through a
//    SYNC_STAGES-deep synchroniser and a stable-count debounce filter. The
//    filter accepts a new level only after it has been seen for DEBOUNCE_CYC
//    consecutive cycles. Accepted edges give one-cycle p_edge/n_edge pulses.
//    A per-channel mode qualifies them into an event pulse and a sticky flag.
//
// Ports:
//    clk_i       clock, all state updates on posedge
//    reset_p_i   synchronous active-high reset
//    cp_i        raw asynchronous inputs, bit i = channel i
//    mode_i      edge mode per channel, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
//    clr_i       per-channel sticky clear, level-sensitive
//    level_o     debounced level
//    p_edge_o    one-cycle pulse on accepted 0->1
//    n_edge_o    one-cycle pulse on accepted 1->0
//    event_o     one-cycle pulse on accepted edge matching mode
//    sticky_o    latched event flag
module edge_detector_multi #(
   parameter int CH           = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic              clk_i,
   input  logic              reset_p_i,
   input  logic [CH-1:0]     cp_i,
   input  logic [2*CH-1:0]   mode_i,
   input  logic [CH-1:0]     clr_i,
   output logic [CH-1:0]     level_o,
   output logic [CH-1:0]     p_edge_o,
   output logic [CH-1:0]     n_edge_o,
   output logic [CH-1:0]     event_o,
   output logic [CH-1:0]     sticky_o
);

   localparam int              CW       = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
   logic [CH-1:0]                  level_q, level_d;
   logic [CH-1:0]                  p_edge_q, p_edge_d;
   logic [CH-1:0]                  n_edge_q, n_edge_d;
   logic [CH-1:0]                  event_q, event_d;
   logic [CH-1:0]                  sticky_q, sticky_d;

   logic [CH-1:0]                  s_out;
   logic [CH-1:0]                  p_acc;
   logic [CH-1:0]                  n_acc;
   logic [CH-1:0]                  ev_hit;

   always_comb begin
      sync_d   = sync_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      p_edge_d = '0;
      n_edge_d = '0;
      event_d  = '0;
      sticky_d = sticky_q;
      s_out    = '0;
      p_acc    = '0;
      n_acc    = '0;
      ev_hit   = '0;

      for (int i = 0; i < CH; i++) begin
         sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], cp_i[i]};
         s_out[i]  = sync_q[i][SYNC_STAGES-1];

         // The counter tracks how many consecutive cycles the synchronised
         // value has disagreed with the accepted level; any agreement restarts it.
         if (s_out[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            level_d[i] = s_out[i];
            cnt_d[i]   = '0;
            p_acc[i]   = s_out[i];
            n_acc[i]   = ~s_out[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end

         // Mode only gates accepted edges, so changing it alone never fires.
         ev_hit[i]   = (p_acc[i] & mode_i[2*i]) | (n_acc[i] & mode_i[2*i+1]);
         p_edge_d[i] = p_acc[i];
         n_edge_d[i] = n_acc[i];
         event_d[i]  = ev_hit[i];
         // A new event takes priority over a simultaneous clear.
         sticky_d[i] = ev_hit[i] | (sticky_q[i] & ~clr_i[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_p_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         level_q  <= '0;
         p_edge_q <= '0;
         n_edge_q <= '0;
         event_q  <= '0;
         sticky_q <= '0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         p_edge_q <= p_edge_d;
         n_edge_q <= n_edge_d;
         event_q  <= event_d;
         sticky_q <= sticky_d;
      end
   end

   assign level_o  = level_q;
   assign p_edge_o = p_edge_q;
   assign n_edge_o = n_edge_q;
   assign event_o  = event_q;
   assign sticky_o = sticky_q;

endmodule

// File: tb/tb_edge_detector_multi.sv
// tb/tb_edge_detector_multi.sv - testbench for edge_detector_multi
module tb_edge_detector_multi;

   localparam int CH = 4;
   localparam int SS = 2;
   localparam int DB = 4;

   typedef struct packed {
      logic [CH-1:0] level;
      logic [CH-1:0] p;
      logic [CH-1:0] n;
      logic [CH-1:0] ev;
      logic [CH-1:0] st;
   } exp_t;

   logic              clk;
   logic              reset_p;
   logic [CH-1:0]     cp;
   logic [2*CH-1:0]   mode;
   logic [CH-1:0]     clr;
   logic [CH-1:0]     level;
   logic [CH-1:0]     p_edge;
   logic [CH-1:0]     n_edge;
   logic [CH-1:0]     event_o;
   logic [CH-1:0]     sticky;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t sb[$];

   logic [CH-1:0] m_pipe [SS];
   int            m_run  [CH];
   logic [CH-1:0] m_level, m_p, m_n, m_ev, m_st;

   int pc [CH];
   int nc [CH];
   int ec [CH];
   int p_at [CH];
   int n_at [CH];

   edge_detector_multi #(.CH(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYC(DB)) dut (
      .clk_i     (clk),
      .reset_p_i (reset_p),
      .cp_i      (cp),
      .mode_i    (mode),
      .clr_i     (clr),
      .level_o   (level),
      .p_edge_o  (p_edge),
      .n_edge_o  (n_edge),
      .event_o   (event_o),
      .sticky_o  (sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < CH; c++) begin
         pc[c] = 0; nc[c] = 0; ec[c] = 0; p_at[c] = -1; n_at[c] = -1;
      end
   endtask

   // Advance one clock: predict the post-edge outputs from the inputs now
   // being driven, queue them, then compare once the edge has happened.
   task automatic tick();
      exp_t e;
      logic s;
      logic acc;
      if (reset_p) begin
         for (int k = 0; k < SS; k++) m_pipe[k] = '0;
         for (int c = 0; c < CH; c++) m_run[c] = 0;
         m_level = '0; m_p = '0; m_n = '0; m_ev = '0; m_st = '0;
      end else begin
         for (int c = 0; c < CH; c++) begin
            s   = m_pipe[SS-1][c];
            acc = 1'b0;
            if (s !== m_level[c]) begin
               m_run[c]++;
               if (m_run[c] == DB) begin
                  acc        = 1'b1;
                  m_run[c]   = 0;
                  m_level[c] = s;
               end
            end else begin
               m_run[c] = 0;
            end
            m_p[c]  = acc & s;
            m_n[c]  = acc & ~s;
            m_ev[c] = (m_p[c] & mode[2*c]) | (m_n[c] & mode[2*c+1]);
            if (m_ev[c]) m_st[c] = 1'b1;
            else if (clr[c]) m_st[c] = 1'b0;
         end
         for (int k = SS-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
         m_pipe[0] = cp;
      end
      e.level = m_level; e.p = m_p; e.n = m_n; e.ev = m_ev; e.st = m_st;
      sb.push_back(e);

      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      checks++;
      assert ({level, p_edge, n_edge, event_o, sticky} === e) else begin
         errors++;
         $error("FAIL model cyc%0d: observed lvl=%b p=%b n=%b ev=%b st=%b expected lvl=%b p=%b n=%b ev=%b st=%b",
                cyc, level, p_edge, n_edge, event_o, sticky, e.level, e.p, e.n, e.ev, e.st);
      end
      for (int c = 0; c < CH; c++) begin
         if (p_edge[c] === 1'b1) begin pc[c]++; p_at[c] = cyc; end
         if (n_edge[c] === 1'b1) begin nc[c]++; n_at[c] = cyc; end
         if (event_o[c] === 1'b1) ec[c]++;
      end
   endtask

   initial begin
      reset_p = 1'b1;
      cp      = '0;
      mode    = 8'hFF;
      clr     = '0;
      clear_stats();

      // Reset state
      tick();
      tick();
      chk("reset_outputs", {12'h0, level, p_edge, n_edge, event_o, sticky}, 32'h0);

      // Channel 0 held high: accepted at edge 6, pulses one cycle only
      reset_p = 1'b0;
      cp      = 4'b0001;
      repeat (5) tick();
      chk("t1_no_early_level", {28'h0, level}, 32'h0);
      tick();
      chk("t1_level_e6", {28'h0, level}, 32'h1);
      chk("t1_pedge_e6", {28'h0, p_edge}, 32'h1);
      chk("t1_event_e6", {28'h0, event_o}, 32'h1);
      chk("t1_sticky_e6", {28'h0, sticky}, 32'h1);
      tick();
      chk("t1_pedge_e7", {28'h0, p_edge}, 32'h0);
      chk("t1_event_e7", {28'h0, event_o}, 32'h0);
      chk("t1_level_e7", {28'h0, level}, 32'h1);
      clr = 4'b0001;
      tick();
      clr = 4'b0000;
      chk("t1_sticky_clr", {28'h0, sticky}, 32'h0);
      tick();

      // Channel 1 glitch shorter than the filter, then a minimum-width pulse
      clear_stats();
      cp[1] = 1'b1;
      repeat (3) tick();
      cp[1] = 1'b0;
      repeat (10) tick();
      chk("t2_glitch_pedge", pc[1], 0);
      chk("t2_glitch_nedge", nc[1], 0);
      chk("t2_glitch_level", {31'h0, level[1]}, 32'h0);
      clear_stats();
      cp[1] = 1'b1;
      repeat (4) tick();
      cp[1] = 1'b0;
      repeat (10) tick();
      chk("t2_pulse_pcount", pc[1], 1);
      chk("t2_pulse_ncount", nc[1], 1);
      chk("t2_pulse_spacing", n_at[1] - p_at[1], 4);

      // Channel 2 rising-only mode
      clear_stats();
      mode = 8'b11_01_11_11;
      cp[2] = 1'b1;
      repeat (8) tick();
      cp[2] = 1'b0;
      repeat (8) tick();
      chk("t3_event_count", ec[2], 1);
      chk("t3_pedge_count", pc[2], 1);
      chk("t3_nedge_count", nc[2], 1);
      chk("t3_sticky", {31'h0, sticky[2]}, 32'h1);

      // Channel 3: event beats simultaneous clear, then clear takes effect
      mode  = 8'hFF;
      cp[3] = 1'b1;
      repeat (8) tick();
      chk("t4_sticky_set", {31'h0, sticky[3]}, 32'h1);
      cp[3] = 1'b0;
      repeat (5) tick();
      clr[3] = 1'b1;
      tick();
      chk("t4_event_with_clr", {31'h0, event_o[3]}, 32'h1);
      chk("t4_sticky_kept", {31'h0, sticky[3]}, 32'h1);
      tick();
      chk("t4_sticky_cleared", {31'h0, sticky[3]}, 32'h0);
      clr[3] = 1'b0;

      // Reset landing on the accepting edge, then re-detection after release
      cp[1] = 1'b1;
      repeat (5) tick();
      chk("t5_pre_reset_level", {31'h0, level[1]}, 32'h0);
      reset_p = 1'b1;
      tick();
      chk("t5_reset_wins", {12'h0, level, p_edge, n_edge, event_o, sticky}, 32'h0);
      reset_p = 1'b0;
      repeat (5) tick();
      chk("t5_no_early_pedge", {28'h0, p_edge}, 32'h0);
      tick();
      chk("t5_pedge_after_release", {28'h0, p_edge}, 32'h3);
      chk("t5_level_after_release", {28'h0, level}, 32'h3);

      // All channels toggle together with mixed modes
      cp = 4'b0000;
      repeat (8) tick();
      mode = 8'b11_10_01_00;
      cp   = 4'b1111;
      repeat (5) tick();
      tick();
      chk("t6_rise_pedge", {28'h0, p_edge}, 32'hF);
      chk("t6_rise_event", {28'h0, event_o}, 32'hA);
      cp = 4'b0000;
      repeat (5) tick();
      tick();
      chk("t6_fall_nedge", {28'h0, n_edge}, 32'hF);
      chk("t6_fall_event", {28'h0, event_o}, 32'hC);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/edge_detector_multi.md
# edge_detector_multi

Multi-channel successor to the single-input edge detector: per channel, the raw input is synchronised, debounced by a programmable stable-count filter, and its rising/falling edges are reported as one-cycle pulses. Per-channel edge-mode selection produces a qualified event pulse and a sticky event flag with individual clear. It sits between asynchronous inputs (push buttons, sensor lines, external strobes) and the clock-domain control FSMs that consume clean single-cycle strobes.

## Interface
Parameters:
- CH, 4, number of independent channels (>= 1)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>= 2)
- DEBOUNCE_CYC, 4, consecutive cycles of a new synchronised value required before acceptance (>= 1; 1 = no filtering)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset_p  in  1  synchronous, active-high reset
- cp  in  CH  raw asynchronous inputs, bit i = channel i
- mode  in  2*CH  per channel edge mode, bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
- clr  in  CH  per channel sticky-flag clear, level-sensitive
- level  out  CH  debounced level
- p_edge  out  CH  one-cycle pulse on accepted 0->1
- n_edge  out  CH  one-cycle pulse on accepted 1->0
- event  out  CH  one-cycle pulse on accepted edge matching mode
- sticky  out  CH  latched event flag

## Operation
- All channels identical and independent; no shared state.
- Synchroniser: per channel shift chain of SYNC_STAGES flops; s_out = last stage.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYC+1), per channel, each posedge:
  - s_out == level: cnt <= 0.
  - s_out != level and cnt == DEBOUNCE_CYC-1: level <= s_out, cnt <= 0, accept.
  - s_out != level otherwise: cnt <= cnt+1.
- Accept with new level 1 -> p_edge <= 1; new level 0 -> n_edge <= 1; otherwise both <= 0 (pulses never stretch beyond one cycle).
- event <= (p-accept & mode[0]) | (n-accept & mode[1]); mode sampled in the accepting cycle; mode change never generates an event by itself.
- sticky: set when event condition true; cleared when clr=1 and no event condition that cycle; event wins over simultaneous clr; clr with sticky already 0 is a no-op.
- Reset (reset_p=1 at posedge): sync chain, cnt, level, p_edge, n_edge, event, sticky all <= 0; reset overrides every other condition, including an accept in the same cycle.
- After reset release with cp held 1: input treated as a genuine 0->1; p_edge fires normally.

## Timing
- cp change before edge k=1 -> s_out changes at edge SYNC_STAGES -> level, p_edge/n_edge, event, sticky update together at edge SYNC_STAGES+DEBOUNCE_CYC (default 6).
- p_edge/n_edge/event high for exactly one cycle; sticky visible the same cycle as event.
- Glitch at s_out lasting fewer than DEBOUNCE_CYC cycles: no level change, no pulses, cnt returns to 0.
- Toggle back while counting: cnt resets on the first cycle s_out == level; restart needs a full DEBOUNCE_CYC.
- Minimum accepted pulse width on cp: DEBOUNCE_CYC cycles; back-to-back accepted edges spaced >= DEBOUNCE_CYC cycles.
- clr effect: sticky low the cycle after the clr posedge; no combinational paths input->output.

## Test plan
- Reset then cp=4'b0001 held, CH=4, SYNC_STAGES=2, DEBOUNCE_CYC=4, mode=8'hFF -> level[0]=1, p_edge[0]=1, event[0]=1, sticky[0]=1 at edge 6; p_edge/event low at edge 7; other channels stay 0.
- cp[1] pulse high 3 cycles (< DEBOUNCE_CYC) -> no change on any output of channel 1; 4-cycle pulse -> p_edge[1] then n_edge[1] each exactly one cycle, 4 cycles apart.
- mode[5:4]=2'b01, channel 2 rises then falls -> event[2] on rise only; n_edge[2] still pulses on fall; sticky[2] set once.
- sticky[3]=1, clr[3]=1 in same cycle as channel-3 accepted event -> sticky[3] stays 1; clr[3] next cycle with no event -> sticky[3]=0.
- reset_p asserted at the edge where level would change -> all outputs 0, cnt 0; after release with cp still 1, p_edge fires 6 cycles later.
- All four channels toggle simultaneously with mode=8'b11_10_01_00 -> p_edge=4'hF, event=4'b1010 on rise; n_edge=4'hF, event=4'b1100 on fall.
